// File: rtl/dfrl_univ.sv
// dfrl_univ: WIDTH-bit universal register with a synchronous active-low reset,
// parallel load, enable, up/down counting, shift and rotate.
//
// Ports:
//   clk        rising-edge clock
//   reset_     synchronous active-low reset; forces out=RESET_VALUE, ovf=0
//   en         enables the count/shift/rotate modes (load ignores en)
//   load       parallel load of in; clears ovf
//   in         parallel load data
//   mode       000 hold, 001 up, 010 down, 011 shl, 100 shr,
//              101 rotl, 110 rotr, 111 hold (reserved)
//   serial_in  bit shifted in by the shift modes
//   out        register contents
//   tc         terminal count, combinational from out and mode, independent of en
//   ovf        sticky count wrap flag, registered
module dfrl_univ #(
    parameter int unsigned       WIDTH       = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       mode,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    localparam int unsigned      MODE_W   = 3;
    localparam logic [MODE_W-1:0] MODE_UP   = 3'b001;
    localparam logic [MODE_W-1:0] MODE_DOWN = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROTL = 3'b101;
    localparam logic [MODE_W-1:0] MODE_ROTR = 3'b110;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ALL_ZERO = '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] next_out;
    logic             wrap;

    // Next value for the enabled, non-load case; wrap flags a count rollover.
    always_comb begin
        next_out = out;
        wrap     = 1'b0;
        case (mode)
            MODE_UP: begin
                next_out = out + ONE;
                wrap     = (out == ALL_ONES);
            end
            MODE_DOWN: begin
                next_out = out - ONE;
                wrap     = (out == ALL_ZERO);
            end
            MODE_SHL:  next_out = {out[WIDTH-2:0], serial_in};
            MODE_SHR:  next_out = {serial_in, out[WIDTH-1:1]};
            MODE_ROTL: next_out = {out[WIDTH-2:0], out[WIDTH-1]};
            MODE_ROTR: next_out = {out[0], out[WIDTH-1:1]};
            default:   next_out = out;
        endcase
    end

    // Storage: reset > load > enabled operation > hold.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            out <= RESET_VALUE;
            ovf <= 1'b0;
        end else if (load) begin
            out <= in;
            ovf <= 1'b0;
        end else if (en) begin
            out <= next_out;
            if (wrap) begin
                ovf <= 1'b1;
            end
        end
    end

    // Terminal count looks at the current value only, so it is valid while en=0.
    assign tc = ((mode == MODE_UP)   && (out == ALL_ONES)) ||
                ((mode == MODE_DOWN) && (out == ALL_ZERO));

endmodule
